// File: rtl/run_host.sv
// rtl/run_host.sv - Load / run / read-back sequencer hosting a processor on a shared data memory
// Optional run-cycle counter is built only when RUN_HOST_CYCCNT_EN is defined.
module run_host #(
  parameter int AW      = 8,
  parameter int LOAD_N  = 64,
  parameter int RD_BASE = 64,
  parameter int RD_N    = 64,
  parameter int TMO     = 4096
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          busy_o,
  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  input  logic [7:0]    ld_data_i,
  output logic          mem_wr_en_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  input  logic [7:0]    mem_rdata_i,
  output logic          req_o,
  input  logic          done_i,
  output logic          rs_valid_o,
  input  logic          rs_ready_i,
  output logic [7:0]    rs_data_o,
  output logic          tmo_err_o,
  output logic [15:0]   cyc_cnt_o
);

  localparam int WW = $clog2(TMO + 1);
  localparam logic [AW-1:0] LOAD_LAST = AW'(LOAD_N - 1);
  localparam logic [AW-1:0] RD_LAST   = AW'(RD_N - 1);
  localparam logic [AW-1:0] RD_BASE_A = AW'(RD_BASE);
  localparam logic [WW-1:0] TMO_LAST  = WW'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PULSE, S_WAIT, S_RADDR, S_RCAP, S_RPRES
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            tmo_q, tmo_d;
  logic [7:0]      rs_data_q, rs_data_d;

  // cnt_q is the load address in LOAD and the read-back index afterwards
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    tmo_d       = tmo_q;
    rs_data_d   = rs_data_q;
    busy_o      = (state_q != S_IDLE);
    ld_ready_o  = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    req_o       = 1'b0;
    rs_valid_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      S_LOAD: begin
        ld_ready_o = 1'b1;
        mem_addr_o = cnt_q;
        if (ld_valid_i) begin
          mem_wr_en_o = 1'b1;
          mem_wdata_o = ld_data_i;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LOAD_LAST) begin
            state_d = S_PULSE;
            cnt_d   = '0;
          end
        end
      end
      S_PULSE: begin
        req_o   = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done is tested first so it wins over a timeout expiring in the same cycle
        if (done_i) begin
          state_d = S_RADDR;
        end else if (wcnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_RADDR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_RADDR: begin
        mem_addr_o = RD_BASE_A + cnt_q;
        state_d    = S_RCAP;
      end
      S_RCAP: begin
        rs_data_d = mem_rdata_i;
        state_d   = S_RPRES;
      end
      S_RPRES: begin
        rs_valid_o = 1'b1;
        if (rs_ready_i) begin
          if (cnt_q == RD_LAST) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_RADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      tmo_q     <= 1'b0;
      rs_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      tmo_q     <= tmo_d;
      rs_data_q <= rs_data_d;
    end
  end

  assign rs_data_o = rs_data_q;
  assign tmo_err_o = tmo_q;

`ifdef RUN_HOST_CYCCNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE && start_i) begin
      cyc_d = '0;
    end else if (state_q == S_WAIT && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc_cnt_o = cyc_q;
`else
  assign cyc_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_run_host.sv
// tb/tb_run_host.sv - Directed self-checking bench for run_host with a transaction-level scoreboard
module tb_run_host;

  localparam int AW      = 8;
  localparam int LOAD_N  = 4;
  localparam int RD_BASE = 64;
  localparam int RD_N    = 2;
  localparam int TMO     = 20;

`ifdef RUN_HOST_CYCCNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          busy_o;
  logic          ld_valid_i;
  logic          ld_ready_o;
  logic [7:0]    ld_data_i;
  logic          mem_wr_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_wdata_o;
  logic [7:0]    mem_rdata_i;
  logic          req_o;
  logic          done_i;
  logic          rs_valid_o;
  logic          rs_ready_i;
  logic [7:0]    rs_data_o;
  logic          tmo_err_o;
  logic [15:0]   cyc_cnt_o;

  run_host #(
    .AW(AW), .LOAD_N(LOAD_N), .RD_BASE(RD_BASE), .RD_N(RD_N), .TMO(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_data_i(ld_data_i),
    .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .req_o(req_o), .done_i(done_i),
    .rs_valid_o(rs_valid_o), .rs_ready_i(rs_ready_i), .rs_data_o(rs_data_o),
    .tmo_err_o(tmo_err_o), .cyc_cnt_o(cyc_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rs [$];
  logic [7:0]  rx_q   [$];
  logic [15:0] w;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Data memory: synchronous write, registered read (data one cycle after address)
  always @(posedge clk_i) begin
    if (mem_wr_en_o) mem[mem_addr_o] = mem_wdata_o;
    mem_rdata_i <= mem[mem_addr_o];
  end

  // Scoreboard: every write and every result handshake is matched against the model queues
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (mem_wr_en_o) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'(mem_addr_o), 32'hFFFF);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_addr_o), 32'(w[15:8]));
          chk("wr_data", 32'(mem_wdata_o), 32'(w[7:0]));
        end
      end
      if (prev_stall) begin
        chk("rs_hold_valid", 32'(rs_valid_o), 32'd1);
        chk("rs_hold_data", 32'(rs_data_o), 32'(prev_data));
      end
      if (rs_valid_o && rs_ready_i) begin
        rx_q.push_back(rs_data_o);
        if (exp_rs.size() == 0) chk("unexpected_rs", 32'(rs_data_o), 32'hFFFF);
        else chk("rs_data", 32'(rs_data_o), 32'(exp_rs.pop_front()));
      end
      prev_stall = rs_valid_o && !rs_ready_i;
      prev_data  = rs_data_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    32'(busy_o),      0);
    chk({tag, "_req"},     32'(req_o),       0);
    chk({tag, "_ldrdy"},   32'(ld_ready_o),  0);
    chk({tag, "_wren"},    32'(mem_wr_en_o), 0);
    chk({tag, "_addr"},    32'(mem_addr_o),  0);
    chk({tag, "_wdata"},   32'(mem_wdata_o), 0);
    chk({tag, "_rsvalid"}, 32'(rs_valid_o),  0);
    chk({tag, "_rsdata"},  32'(rs_data_o),   0);
    chk({tag, "_tmo"},     32'(tmo_err_o),   0);
    chk({tag, "_cyc"},     32'(cyc_cnt_o),   0);
  endtask

  task automatic start_run;
    tick;
    start_i = 1'b1;
    @(negedge clk_i);
    chk("idle_busy", 32'(busy_o), 0);
  endtask

  // Streams LOAD_N bytes (one stall cycle before byte gap_at, if in range), ends in the req cycle
  task automatic do_load(input logic [31:0] bytes_w, input int gap_at, input logic done_in_pulse);
    for (int i = 0; i < LOAD_N; i++) begin
      if (i == gap_at) begin
        tick;
        start_i    = 1'b0;
        ld_valid_i = 1'b0;
        @(negedge clk_i);
        chk("stall_wren", 32'(mem_wr_en_o), 0);
        chk("stall_ldrdy", 32'(ld_ready_o), 1);
      end
      tick;
      start_i    = 1'b0;
      ld_valid_i = 1'b1;
      ld_data_i  = bytes_w[8*i +: 8];
      exp_wr.push_back({8'(i), ld_data_i});
      ref_mem[i] = ld_data_i;
      @(negedge clk_i);
      chk("ld_wren", 32'(mem_wr_en_o), 1);
      chk("ld_addr", 32'(mem_addr_o), 32'(i));
    end
    tick;
    ld_valid_i = 1'b0;
    done_i     = done_in_pulse;
    @(negedge clk_i);
    chk("req_pulse", 32'(req_o), 1);
    chk("pulse_ldrdy", 32'(ld_ready_o), 0);
  endtask

  // done_k: WAIT cycle (1-based) in which done is high, 0 = never; len: WAIT cycles expected
  task automatic run_wait(input int done_k, input int len, input logic exp_tmo, input int exp_cyc);
    for (int k = 1; k <= len; k++) begin
      tick;
      done_i = (k == done_k);
      @(negedge clk_i);
      chk("wait_rsvalid", 32'(rs_valid_o), 0);
      if (k == 1) chk("req_single", 32'(req_o), 0);
      if (k == len) chk("wait_tmo_before", 32'(tmo_err_o), 0);
    end
    tick;
    done_i = 1'b0;
    @(negedge clk_i);
    chk("run_tmo_err", 32'(tmo_err_o), 32'(exp_tmo));
    chk("run_cyc_cnt", 32'(cyc_cnt_o), CYC_EN ? 32'(exp_cyc) : 32'd0);
    chk("raddr_addr", 32'(mem_addr_o), 32'(RD_BASE));
  endtask

  task automatic read_back(input int stall_n, input logic [7:0] b0, input logic [7:0] b1);
    int t, hs, stalled, t_first;
    t = 0; hs = 0; stalled = 0; t_first = 0;
    rx_q.delete();
    for (int i = 0; i < RD_N; i++) exp_rs.push_back(ref_mem[8'(RD_BASE + i)]);
    while (hs < RD_N && t < 40) begin
      tick;
      t++;
      rs_ready_i = !(rs_valid_o && hs == 0 && stalled < stall_n);
      if (!rs_ready_i) stalled++;
      @(negedge clk_i);
      if (rs_valid_o && rs_ready_i) begin
        hs++;
        if (hs == 1) t_first = t;
        else chk("rs_spacing", 32'(t - t_first), 3);
      end
    end
    chk("rs_handshakes", 32'(hs), 32'(RD_N));
    chk("rs_first_cycle", 32'(t_first), 32'(2 + stall_n));
    tick;
    @(negedge clk_i);
    chk("end_busy", 32'(busy_o), 0);
    chk("rs_count", 32'(rx_q.size()), 32'(RD_N));
    chk("rs_pending", 32'(exp_rs.size()), 0);
    if (rx_q.size() == RD_N) begin
      chk("rs_byte0", 32'(rx_q[0]), 32'(b0));
      chk("rs_byte1", 32'(rx_q[1]), 32'(b1));
    end
  endtask

  initial begin
    int nreq;
    rst_ni = 1'b0; start_i = 1'b0; ld_valid_i = 1'b0; ld_data_i = 8'h00;
    done_i = 1'b0; rs_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i ^ 8'h5A);
      ref_mem[i] = 8'(i ^ 8'h5A);
    end
    mem[64] = 8'hAA; ref_mem[64] = 8'hAA;
    mem[65] = 8'h55; ref_mem[65] = 8'h55;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;

    // Gapless load of 11,22,33,44; done in the 10th WAIT cycle; reads AA,55
    start_run();
    do_load(32'h44332211, -1, 1'b0);
    run_wait(10, 10, 1'b0, 10);
    read_back(0, 8'hAA, 8'h55);

    // done held during PULSE is ignored; done on the timeout cycle wins
    mem[64] = 8'h3C; ref_mem[64] = 8'h3C;
    mem[65] = 8'hC3; ref_mem[65] = 8'hC3;
    start_run();
    do_load(32'hD4C3B2A1, 1, 1'b1);
    run_wait(TMO, TMO, 1'b0, TMO);
    read_back(0, 8'h3C, 8'hC3);

    // Timeout with done held low, then a 5-cycle consumer stall on the first byte
    start_run();
    do_load(32'h0F0E0D0C, 2, 1'b0);
    run_wait(0, TMO, 1'b1, TMO);
    read_back(5, 8'h3C, 8'hC3);

    // Asynchronous reset in WAIT with start held high
    start_run();
    do_load(32'h87654321, -1, 1'b0);
    for (int k = 0; k < 5; k++) tick;
    start_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1 chk_all_zero("rst_async");
    tick;
    chk("rst_hold_busy", 32'(busy_o), 0);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_release_busy", 32'(busy_o), 0);
    nreq = 0;
    for (int k = 1; k <= 25; k++) begin
      tick;
      @(negedge clk_i);
      if (k == 1) begin
        chk("restart_busy", 32'(busy_o), 1);
        chk("restart_ldrdy", 32'(ld_ready_o), 1);
      end
      if (req_o) nreq++;
    end
    chk("no_req_after_reset", 32'(nreq), 0);
    do_load(32'h99887766, -1, 1'b0);
    run_wait(3, 3, 1'b0, 3);
    read_back(0, 8'h3C, 8'hC3);
    chk("wr_pending", 32'(exp_wr.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/run_host.md
RUN_HOST -- requirements
Module: run_host

Interface
REQ-001 Parameter AW, default 8: processor data-memory address width.
REQ-002 Parameter LOAD_N, default 64: bytes written to data memory before each run, at addresses 0..LOAD_N-1.
REQ-003 Parameter RD_BASE, default 64: first data-memory address read back after a run.
REQ-004 Parameter RD_N, default 64: bytes read back, at addresses RD_BASE..RD_BASE+RD_N-1, modulo 2^AW.
REQ-005 Parameter TMO, default 4096: maximum number of cycles to wait for done.
REQ-006 clk  in  1  single clock; all state updates on posedge.
REQ-007 reset  in  1  asynchronous, active-low (asserted at 0).
REQ-008 start  in  1  begin a run sequence; sampled only in IDLE.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 ld_valid / ld_ready / ld_data  in / out / 8  load-byte stream.
REQ-011 mem_wr_en / mem_addr / mem_wdata  out / out AW / out 8  data-memory port.
REQ-012 mem_rdata  in  8  read data, valid one cycle after mem_addr is presented.
REQ-013 req  out  1  run request to the processor.
REQ-014 done  in  1  processor completion level.
REQ-015 rs_valid / rs_ready / rs_data  out / in / 8  result stream.
REQ-016 tmo_err  out  1  sticky flag: the last run timed out.
REQ-017 cyc_cnt  out  16  cycles from the req pulse to done.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, PULSE, WAIT, RADDR, RCAP, RPRES.
REQ-019 IDLE -> LOAD on start=1; entering LOAD SHALL clear tmo_err, cyc_cnt and the address counter.
REQ-020 LOAD behaviour:
- ld_ready SHALL be 1.
- On each ld_valid&ld_ready cycle, mem_wr_en SHALL be 1, with mem_addr=count and mem_wdata=ld_data.
- The count increments after each accepted byte.
- After byte LOAD_N-1 is written, the FSM goes to PULSE.
- ld_valid=0 stalls the load with no write.
REQ-021 In any state other than LOAD, ld_ready SHALL be 0 and mem_wr_en SHALL be 0.
REQ-022 PULSE: req SHALL be 1 for exactly one cycle, then the FSM goes to WAIT; the done level during PULSE SHALL be ignored.
REQ-023 WAIT behaviour:
- cyc_cnt increments each cycle, saturating at 16'hFFFF.
- done=1 -> RADDR.
- If TMO cycles elapse with done=0: set tmo_err, then -> RADDR.
- If done rises on the same cycle that the timeout expires, done SHALL win and tmo_err stays 0.
REQ-024 Read-back behaviour:
- RADDR presents mem_addr=RD_BASE+index.
- RCAP registers mem_rdata into rs_data.
- RPRES holds rs_valid=1 with rs_data stable until rs_ready=1.
- After the handshake: -> RADDR, or -> IDLE after index RD_N-1.
REQ-025 rs_valid SHALL be 1 only in RPRES; with rs_ready held at 1, one byte SHALL transfer every 3 cycles.
REQ-026 start asserted while busy=1 SHALL be ignored.
REQ-027 Address arithmetic SHALL be AW bits wide and wrap modulo 2^AW.

Reset
REQ-028 reset=0 SHALL immediately return the FSM to IDLE, regardless of clk or current state.
REQ-029 While reset=0, every output SHALL be 0: busy, req, ld_ready, mem_wr_en, mem_addr, mem_wdata, rs_valid, rs_data, tmo_err, cyc_cnt.
REQ-030 Reset asserted mid-run SHALL abandon the sequence; partial memory contents are not restored, and no req SHALL be issued afterwards.

Configuration
REQ-031 Macro RUN_HOST_CYCCNT_EN:
- Defined: cyc_cnt behaves per REQ-023.
- Undefined: the counter logic is omitted and cyc_cnt is tied to 16'd0.
- The timeout detection SHALL be functional in both builds.

Verification
REQ-032 LOAD_N=4, bytes 11,22,33,44 sent with no gaps -> writes to addr 0..3 on 4 consecutive cycles, then a single req pulse.
REQ-033 done rises 10 cycles after the req pulse, RD_N=2, memory at 64/65 holding AA/55 -> rs_data AA then 55, cyc_cnt=10, tmo_err=0.
REQ-034 TMO=20, done held at 0 -> tmo_err=1 exactly 20 cycles after the req pulse, then read-back proceeds.
REQ-035 rs_ready held at 0 for 5 cycles during RPRES -> rs_valid stays 1 and rs_data stays unchanged, then exactly one transfer occurs.
REQ-036 reset=0 applied during WAIT with start held at 1 -> outputs 0 asynchronously; after release the FSM restarts in LOAD and req does not pulse until a new load completes.
REQ-037 Build without RUN_HOST_CYCCNT_EN, repeat the REQ-033 scenario -> cyc_cnt=0 and read data still correct.
